// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
// State encoding is visible on o_state for the control/status registers.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } spi_state_e;

    localparam int SPI_FRAME_BITS = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus one history flop
// that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Byte-wide LSB-first SPI slave, all four CPOL/CPHA modes, oversampled in i_clk.
// i_load is a bare one-cycle strobe: no handshake, the byte is captured on that cycle.
module spi_slave
    import spi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cpol,
    input  logic       i_cpha,
    input  logic       i_en,
    input  logic [7:0] i_data_slave,
    input  logic       i_load,
    input  logic       i_clr_flg,
    input  logic       i_SCK,
    input  logic       i_CS,
    input  logic       i_MOSI,
    output logic       o_MISO,
    output logic       o_MISO_oe,
    output logic [7:0] o_data_slave,
    output logic       o_done,
    output logic       o_ovr,
    output logic [1:0] o_state,
    output logic [3:0] o_bits
);

    logic w_sck_rise, w_sck_fall, w_unused_sck_level;
    logic w_cs, w_cs_fall, w_unused_cs_rise;
    logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_SCK),
        .o_level(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_CS),
        .o_level(w_cs), .o_rise(w_unused_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_MOSI),
        .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    spi_state_e r_state, w_state_nxt;
    logic [3:0] r_bits, w_bits_nxt;
    logic [7:0] r_tx_hold, w_tx_hold_nxt;
    logic [7:0] r_tx_shift, w_tx_shift_nxt;
    logic [7:0] r_rx_shift, w_rx_shift_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic       r_done, w_done_nxt;
    logic       r_ovr, w_ovr_nxt;
    logic       r_fresh, w_fresh_nxt;
    logic       r_cpol, w_cpol_nxt;
    logic       r_cpha, w_cpha_nxt;

    // Mode bits are frozen for the frame once the FSM leaves StIdle.
    logic w_lead, w_trail, w_sample, w_shift;
    assign w_lead   = r_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail  = r_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : w_trail;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= StIdle;
            r_bits     <= 4'd0;
            r_tx_hold  <= 8'h00;
            r_tx_shift <= 8'h00;
            r_rx_shift <= 8'h00;
            r_data     <= 8'h00;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_fresh    <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bits     <= w_bits_nxt;
            r_tx_hold  <= w_tx_hold_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_ovr      <= w_ovr_nxt;
            r_fresh    <= w_fresh_nxt;
            r_cpol     <= w_cpol_nxt;
            r_cpha     <= w_cpha_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bits_nxt     = r_bits;
        w_tx_hold_nxt  = i_load ? i_data_slave : r_tx_hold;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_data_nxt     = r_data;
        w_done_nxt     = r_done;
        w_ovr_nxt      = r_ovr;
        w_fresh_nxt    = 1'b0;
        w_cpol_nxt     = r_cpol;
        w_cpha_nxt     = r_cpha;

        if (i_clr_flg) begin
            w_done_nxt = 1'b0;
            w_ovr_nxt  = 1'b0;
        end

        case (r_state)
            StIdle: begin
                w_bits_nxt = 4'd0;
                w_cpol_nxt = i_cpol;
                w_cpha_nxt = i_cpha;
                if (w_cs_fall && i_en) begin
                    w_tx_shift_nxt = r_tx_hold;
                    w_state_nxt    = StShift;
                end
            end
            StShift: begin
                if (w_cs || !i_en) begin
                    w_state_nxt = StIdle;
                    w_bits_nxt  = 4'd0;
                end else if (w_sample) begin
                    w_rx_shift_nxt = {w_mosi, r_rx_shift[7:1]};
                    w_bits_nxt     = r_bits + 4'd1;
                    if (r_bits == 4'(SPI_FRAME_BITS - 1)) begin
                        w_state_nxt = StDone;
                        w_fresh_nxt = 1'b1;
                    end
                end else if (w_shift && r_bits != 4'd0) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                end
            end
            StDone: begin
                // First StDone cycle publishes the byte; a same-cycle clear loses to it.
                if (r_fresh) begin
                    w_data_nxt = r_rx_shift;
                    if (i_clr_flg) begin
                        w_done_nxt = 1'b1;
                        w_ovr_nxt  = 1'b0;
                    end else if (r_done) begin
                        w_ovr_nxt = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else if (w_cs) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign o_MISO       = r_tx_shift[0];
    assign o_MISO_oe    = i_en & ~w_cs;
    assign o_data_slave = r_data;
    assign o_done       = r_done;
    assign o_ovr        = r_ovr;
    assign o_state      = r_state;
    assign o_bits       = r_bits;

endmodule
